// File: rtl/regfile_multiport_pkg.sv
// Shared types for the multiport register file: clear-sequencer state encoding
// and the supported read-port range.
package regfile_multiport_pkg;

   // CLEAR: the array is being zeroed one entry per cycle. RUN: normal operation.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } rf_state_e;

   localparam int MIN_RD_PORTS = 1;
   localparam int MAX_RD_PORTS = 4;

endpackage

// File: rtl/regfile_multiport_clear_seq.sv
// Clear sequencer: after reset or a clear request, walks every array entry once.
// The state is exported on state_o so the parent and checkers can observe it.
// No handshake is involved: clear_req_i is a level sampled only in RUN.
module regfile_multiport_clear_seq
   import regfile_multiport_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear_req_i,
   output logic [ADDR_W-1:0] clr_addr_o,
   output logic              ready_o,
   output rf_state_e         state_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   // One extra counter bit so the terminal value never aliases entry 0.
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

   rf_state_e       state_q, state_d;
   logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;

   // State and counter registers; reset restarts the sweep at entry 0.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Next state: sweep to the last entry, then run until a clear request.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == LAST_CNT) begin
               state_d   = ST_RUN;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (clear_req_i) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
         end
      endcase
   end

   assign clr_addr_o = clr_cnt_q[ADDR_W-1:0];
   assign ready_o    = (state_q == ST_RUN);
   assign state_o    = state_q;

endmodule

// File: rtl/regfile_multiport.sv
// Architectural register file: NUM_RD combinational read ports, one write port,
// hardwired-zero entry 0, write-to-read bypass, read-only entries and a
// sequential clear engine that replaces per-entry reset flops.
module regfile_multiport
   import regfile_multiport_pkg::*;
#(
   parameter int                       DATA_W    = 32,
   parameter int                       ADDR_W    = 5,
   parameter int                       NUM_RD    = 2,
   parameter int                       ZERO_REG  = 1,
   parameter int                       BYPASS_EN = 1,
   parameter logic [(2**ADDR_W)-1:0]   RO_MASK   = 32'h8000_0000,
   parameter logic [DATA_W-1:0]        RO_VALUE  = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     wr_err,
   input  logic                     clear_req,
   output logic                     ready
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              wr_err_q, wr_err_d;

   rf_state_e         clr_state;
   logic [ADDR_W-1:0] clr_addr;
   logic              clr_ready;
   logic              clr_we;
   logic [DATA_W-1:0] clr_val;

   logic              wr_protected;
   logic              wr_accept;
   logic              arr_we;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_data;

   regfile_multiport_clear_seq #(
      .ADDR_W (ADDR_W)
   ) u_clear_seq (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear_req_i (clear_req),
      .clr_addr_o  (clr_addr),
      .ready_o     (clr_ready),
      .state_o     (clr_state)
   );

   // The sweep writes one entry in every CLEAR cycle.
   assign clr_we  = (clr_state == ST_CLEAR);
   assign clr_val = RO_MASK[clr_addr] ? RO_VALUE : '0;
   assign ready   = clr_ready;

   assign wr_protected = ((ZERO_REG != 0) && (wr_addr == '0)) || RO_MASK[wr_addr];
   assign wr_accept    = we && clr_ready && !clear_req && !wr_protected;

   // Single array write port: clear writes and user writes never overlap
   // because user writes need ready, which is low for the whole sweep.
   always_comb begin
      arr_we   = 1'b0;
      arr_addr = wr_addr;
      arr_data = wr_data;
      if (clr_we) begin
         arr_we   = 1'b1;
         arr_addr = clr_addr;
         arr_data = clr_val;
      end else if (wr_accept) begin
         arr_we   = 1'b1;
      end
   end

   // Array storage; deliberately not reset, the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (arr_we) begin
         mem_q[arr_addr] <= arr_data;
      end
   end

   // Any write attempt that is not accepted is flagged for one cycle.
   always_comb begin
      wr_err_d = we && !wr_accept;
   end

   // Error pulse register, cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_err_d;
      end
   end

   assign wr_err = wr_err_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = rd_addr[k*ADDR_W +: ADDR_W];

      // Read mux: not-ready, then zero entry, then bypass, then array.
      always_comb begin
         data = mem_q[addr];
         if (!clr_ready) begin
            data = '0;
         end else if ((ZERO_REG != 0) && (addr == '0)) begin
            data = '0;
         end else if ((BYPASS_EN != 0) && wr_accept && (wr_addr == addr)) begin
            data = wr_data;
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = data;
   end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: a bypass build and a no-bypass
// build share all inputs; directed vectors plus clear/reset sequences.
module tb_regfile_multiport;

   logic        clk;
   logic        reset_n;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [63:0] rd_data_nb;
   logic        we;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wr_err;
   logic        wr_err_nb;
   logic        clear_req;
   logic        ready;
   logic        ready_nb;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] e1nb;
      logic        eerr;
   } vec_t;

   vec_t vecs [10];

   regfile_multiport u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_err    (wr_err),
      .clear_req (clear_req),
      .ready     (ready)
   );

   regfile_multiport #(
      .BYPASS_EN (0)
   ) u_dut_nb (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data_nb),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_err    (wr_err_nb),
      .clear_req (clear_req),
      .ready     (ready_nb)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
   endtask

   // Counts cycles with ready low. Optional events at given counts:
   // a rejected write, an (ignored) clear request, a restarting reset pulse.
   task automatic count_clear(input int req_at, input int rst_at, input int we_at,
                              output int n);
      int rst_pending;
      rst_pending = rst_at;
      n = 0;
      while (!ready && n < 100) begin
         if (n == we_at) begin
            we = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFE_0009;
         end
         if (n == we_at + 1) begin
            we = 1'b0;
            check("wr_err_during_clear", {31'd0, wr_err}, 32'd1);
         end
         if (n == req_at)     clear_req = 1'b1;
         if (n == req_at + 1) clear_req = 1'b0;
         if (n == rst_pending) begin
            rst_pending = -10;
            reset_n = 1'b0;
            tick();
            check("ready_in_reset_pulse", {31'd0, ready}, 32'd0);
            check("wr_err_in_reset_pulse", {31'd0, wr_err}, 32'd0);
            reset_n = 1'b1;
            n = 0;
         end else begin
            n++;
            tick();
         end
      end
   endtask

   initial begin
      int n;
      vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[2] = '{1'b1, 5'd7,  32'h0000_1234, 5'd0,  5'd7,  32'h0,         32'h0000_1234, 32'h0,         1'b0};
      vecs[3] = '{1'b1, 5'd0,  32'h0000_FFFF, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         1'b1};
      vecs[4] = '{1'b1, 5'd31, 32'h0000_AAAA, 5'd31, 5'd31, 32'h0,         32'h0,         32'h0,         1'b1};
      vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd9,  32'h0000_1234, 32'h0,         32'h0,         1'b0};
      vecs[6] = '{1'b1, 5'd3,  32'h0000_0055, 5'd3,  5'd5,  32'h0000_0055, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
      vecs[7] = '{1'b1, 5'd12, 32'hA5A5_A5A5, 5'd12, 5'd31, 32'hA5A5_A5A5, 32'h0,         32'h0,         1'b0};
      vecs[8] = '{1'b1, 5'd12, 32'h5A5A_5A5A, 5'd12, 5'd12, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 1'b0};
      vecs[9] = '{1'b0, 5'd0,  32'h0,         5'd12, 5'd3,  32'h5A5A_5A5A, 32'h0000_0055, 32'h0000_0055, 1'b0};

      reset_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0;
      set_rd(5'd0, 5'd0);

      // Reset for two cycles
      tick();
      tick();
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_wr_err", {31'd0, wr_err}, 32'd0);
      check("reset_rd0", rd_data[31:0], 32'h0);
      reset_n = 1'b1;

      // Initial clear, with a rejected write at clear cycle 10
      count_clear(1000, 1000, 10, n);
      check("initial_clear_cycles", n, 32);
      check("ready_nb_after_clear", {31'd0, ready_nb}, 32'd1);
      for (int i = 0; i < 32; i++) begin
         set_rd(5'(i), 5'(31 - i));
         #1;
         check("post_clear_rd0", rd_data[31:0], 32'h0);
         check("post_clear_rd1", rd_data[63:32], 32'h0);
      end

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         we = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
         set_rd(vecs[i].ra0, vecs[i].ra1);
         #2;
         check($sformatf("vec%0d_rd0", i), rd_data[31:0], vecs[i].e0);
         check($sformatf("vec%0d_rd1", i), rd_data[63:32], vecs[i].e1);
         check($sformatf("vec%0d_rd1_nobypass", i), rd_data_nb[63:32], vecs[i].e1nb);
         tick();
         we = 1'b0;
         check($sformatf("vec%0d_wr_err", i), {31'd0, wr_err}, {31'd0, vecs[i].eerr});
         check($sformatf("vec%0d_wr_err_nobypass", i), {31'd0, wr_err_nb}, {31'd0, vecs[i].eerr});
      end

      // Clear request in RUN drops the same-cycle write and never forwards it
      clear_req = 1'b1; we = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
      set_rd(5'd4, 5'd3);
      #1;
      check("clrreq_no_forward", rd_data[31:0], 32'h0);
      check("clrreq_rd_before", rd_data[63:32], 32'h55);
      tick();
      clear_req = 1'b0; we = 1'b0;
      check("clrreq_wr_err", {31'd0, wr_err}, 32'd1);
      check("clrreq_ready_low", {31'd0, ready}, 32'd0);
      check("clrreq_rd_while_clearing", rd_data[63:32], 32'h0);
      count_clear(5, 1000, 1000, n);
      check("clrreq_clear_cycles", n, 32);
      set_rd(5'd3, 5'd4);
      #1;
      check("clrreq_entry3_zero", rd_data[31:0], 32'h0);
      check("clrreq_entry4_zero", rd_data[63:32], 32'h0);

      // Reset pulse at clear cycle 20 restarts the full sweep
      we = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
      tick();
      we = 1'b0;
      check("rewrite_wr_err", {31'd0, wr_err}, 32'd0);
      set_rd(5'd3, 5'd3);
      #1;
      check("rewrite_entry3", rd_data[31:0], 32'h55);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      count_clear(1000, 20, 1000, n);
      check("restart_clear_cycles", n, 32);
      #1;
      check("restart_entry3_zero", rd_data[31:0], 32'h0);
      check("restart_ready", {31'd0, ready}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
